// File: rtl/div32_seq_ctrl.sv
// div32_seq_ctrl: sequential 32-bit restoring divider controller.
// One shared resta32bits subtractor does every trial subtraction and negation,
// producing one quotient bit per cycle.
// Optional feature macro: DIV32_SIGNED_EN (two's-complement operands, adds
// ABS_A/ABS_B/FIX_Q/FIX_R states; latency 37 instead of 33).

// 32-bit subtractor: diff = a - b, cout = 1 means no borrow (a >= b unsigned).
module resta32bits (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        cout
);

   logic [32:0] sum;

   // a + ~b + 1 in 33 bits; the carry out is the inverted borrow
   assign sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
   assign diff = sum[31:0];
   assign cout = sum[32];

endmodule

module div32_seq_ctrl #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_zero
);

   // The shared subtractor is fixed at 32 bits, so no other width can work.
   if (N != 32) begin : g_bad_n
      $error("div32_seq_ctrl: N must be 32");
   end
   if ((64'd1 << CNT_W) <= 64'(N)) begin : g_bad_cnt_w
      $error("div32_seq_ctrl: CNT_W too small to hold N");
   end

`ifdef DIV32_SIGNED_EN
   typedef enum logic [2:0] {
      StIdle,
      StAbsA,
      StAbsB,
      StIter,
      StFixQ,
      StFixR,
      StDone
   } state_e;
`else
   typedef enum logic [1:0] {
      StIdle,
      StIter,
      StDone
   } state_e;
`endif

   state_e           state_q, state_d;
   logic [N-1:0]     q_q, q_d;       // working quotient / shifting dividend
   logic [N-1:0]     r_q, r_d;       // partial remainder
   logic [N-1:0]     dvs_q, dvs_d;   // latched divisor (magnitude in signed mode)
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     quot_q, quot_d;
   logic [N-1:0]     rem_q, rem_d;
   logic             dz_q, dz_d;
`ifdef DIV32_SIGNED_EN
   logic             sa_q, sa_d;     // dividend was negative
   logic             sb_q, sb_d;     // divisor was negative
`endif

   logic [N-1:0]     sub_a, sub_b, sub_diff;
   logic             sub_cout;
   logic [N-1:0]     trial;
   logic             accept;
   logic [N-1:0]     q_step, r_step;

   resta32bits u_sub (
      .a    (sub_a),
      .b    (sub_b),
      .diff (sub_diff),
      .cout (sub_cout)
   );

   // Low 32 bits of the shifted partial remainder; R[31] is its implicit bit 32.
   assign trial = {r_q[N-2:0], q_q[N-1]};

   // If the shifted remainder overflowed 32 bits it is certainly >= divisor.
   assign accept = r_q[N-1] | sub_cout;

   assign q_step = {q_q[N-2:0], accept};
   assign r_step = accept ? sub_diff : trial;

   // Next-state, datapath updates and subtractor operand selection.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
`ifdef DIV32_SIGNED_EN
      sa_d    = sa_q;
      sb_d    = sb_q;
`endif
      // Subtractor idles at 0 - 0 unless a state needs it.
      sub_a   = '0;
      sub_b   = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               q_d   = dividend;
               r_d   = '0;
               dvs_d = divisor;
               cnt_d = CNT_W'(N);
`ifdef DIV32_SIGNED_EN
               sa_d  = dividend[N-1];
               sb_d  = divisor[N-1];
`endif
               if (divisor == '0) begin
                  state_d = StDone;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
               end else begin
`ifdef DIV32_SIGNED_EN
                  state_d = StAbsA;
`else
                  state_d = StIter;
`endif
               end
            end
         end

`ifdef DIV32_SIGNED_EN
         // Magnitude of the dividend; the cycle is spent either way.
         StAbsA: begin
            sub_b   = q_q;
            if (sa_q) begin
               q_d = sub_diff;
            end
            state_d = StAbsB;
         end

         // Magnitude of the divisor.
         StAbsB: begin
            sub_b   = dvs_q;
            if (sb_q) begin
               dvs_d = sub_diff;
            end
            state_d = StIter;
         end
`endif

         StIter: begin
            sub_a = trial;
            sub_b = dvs_q;
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
`ifdef DIV32_SIGNED_EN
               state_d = StFixQ;
`else
               state_d = StDone;
               quot_d  = q_step;
               rem_d   = r_step;
               dz_d    = 1'b0;
`endif
            end
         end

`ifdef DIV32_SIGNED_EN
         // Quotient is negative when the operand signs differ.
         StFixQ: begin
            sub_b   = q_q;
            if (sa_q ^ sb_q) begin
               q_d = sub_diff;
            end
            state_d = StFixR;
         end

         // Remainder takes the sign of the dividend.
         StFixR: begin
            sub_b   = r_q;
            if (sa_q) begin
               r_d = sub_diff;
            end
            state_d = StDone;
            quot_d  = q_q;
            rem_d   = sa_q ? sub_diff : r_q;
            dz_d    = 1'b0;
         end
`endif

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         q_q     <= '0;
         r_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
`ifdef DIV32_SIGNED_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
`ifdef DIV32_SIGNED_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
`endif
      end
   end

   assign busy      = (state_q != StIdle) && (state_q != StDone);
   assign done      = (state_q == StDone);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_div32_seq_ctrl.sv
// Testbench for div32_seq_ctrl: table-driven vectors plus hand sequences,
// expected results queued at issue and compared when done is seen.
module tb_div32_seq_ctrl;

`ifdef DIV32_SIGNED_EN
   localparam int Lat = 37;
`else
   localparam int Lat = 33;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   div32_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
      int          bsy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] last_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic [31:0] q, input logic [31:0] r,
                                   input logic dz);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.lat = dz ? 1 : Lat;
      e.bsy = dz ? 0 : Lat - 1;
      return e;
   endfunction

   // Reference model: plain arithmetic on wide integers.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      longint qq, rr, sa, sbv;
      logic [63:0] qv, rv;
      if (b == 32'd0) return mk_exp(32'hFFFF_FFFF, a, 1'b1);
`ifdef DIV32_SIGNED_EN
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
`else
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
`endif
      qq = sa / sbv;
      rr = sa % sbv;
      qv = qq;
      rv = rr;
      return mk_exp(qv[31:0], rv[31:0], 1'b0);
   endfunction

   // Drive a start in the current (idle) cycle; returns just after edge 0.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Wait for done, optionally pulsing start at cycle glitch; then score.
   task automatic collect(input int glitch);
      int   lat;
      int   bc;
      bit   tmo;
      exp_t e;
      lat = 1;
      bc  = 0;
      tmo = 1'b0;
      while (1) begin
         if (busy) bc++;
         if (done) break;
         if (lat >= 100) begin
            tmo = 1'b1;
            break;
         end
         if (lat == glitch) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (tmo) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
      end
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: got done with nothing expected, required an entry");
      end else begin
         e = sb.pop_front();
         check("quotient", quotient, e.q);
         check("remainder", remainder, e.r);
         check("div_zero", 32'(div_zero), 32'(e.dz));
         check("latency", 32'(lat), 32'(e.lat));
         check("busy_cycles", 32'(bc), 32'(e.bsy));
         last_q = e.q;
      end
   endtask

   // Full operation from idle, then confirm done is a pulse and results hold.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e);
      sb.push_back(e);
      launch(a, b);
      collect(0);
      @(posedge clk);
      #1;
      check("done_pulse", 32'(done), 32'd0);
      check("quotient_held", quotient, last_q);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      last_q   = '0;

`ifdef DIV32_SIGNED_EN
      vecs.push_back('{a:32'hFFFF_FFF9, b:32'd2, q:32'hFFFF_FFFD, r:32'hFFFF_FFFF, dz:1'b0});
      vecs.push_back('{a:32'd7, b:32'hFFFF_FFFE, q:32'hFFFF_FFFD, r:32'd1, dz:1'b0});
      vecs.push_back('{a:32'h8000_0000, b:32'hFFFF_FFFF, q:32'h8000_0000, r:32'd0, dz:1'b0});
      vecs.push_back('{a:32'hFFFF_FF9C, b:32'hFFFF_FFF9, q:32'd14, r:32'hFFFF_FFFE, dz:1'b0});
      vecs.push_back('{a:32'd1234, b:32'd0, q:32'hFFFF_FFFF, r:32'd1234, dz:1'b1});
      vecs.push_back('{a:32'h7FFF_FFFF, b:32'd16, q:32'h07FF_FFFF, r:32'd15, dz:1'b0});
      vecs.push_back('{a:32'd100, b:32'd7, q:32'd14, r:32'd2, dz:1'b0});
`else
      vecs.push_back('{a:32'hFFFF_FFFF, b:32'h0000_0010, q:32'h0FFF_FFFF, r:32'hF, dz:1'b0});
      vecs.push_back('{a:32'h8000_0000, b:32'hFFFF_FFFF, q:32'd0, r:32'h8000_0000, dz:1'b0});
      vecs.push_back('{a:32'hFFFF_FFFF, b:32'h8000_0001, q:32'd1, r:32'h7FFF_FFFE, dz:1'b0});
      vecs.push_back('{a:32'd1234, b:32'd0, q:32'hFFFF_FFFF, r:32'd1234, dz:1'b1});
      vecs.push_back('{a:32'd1000, b:32'd10, q:32'd100, r:32'd0, dz:1'b0});
      vecs.push_back('{a:32'd0, b:32'd5, q:32'd0, r:32'd0, dz:1'b0});
      vecs.push_back('{a:32'd5, b:32'd9, q:32'd0, r:32'd5, dz:1'b0});
      vecs.push_back('{a:32'hDEAD_BEEF, b:32'd1, q:32'hDEAD_BEEF, r:32'd0, dz:1'b0});
      vecs.push_back('{a:32'h1234_5678, b:32'h1000, q:32'h0001_2345, r:32'h678, dz:1'b0});
      vecs.push_back('{a:32'd100, b:32'd7, q:32'd14, r:32'd2, dz:1'b0});
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, mk_exp(vecs[i].q, vecs[i].r, vecs[i].dz));
      end

      // Asynchronous reset in the middle of an operation (cycle 10)
      launch(32'd999_999, 32'd13);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("midop_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_quotient", quotient, 32'd0);
      check("arst_remainder", remainder, 32'd0);
      check("arst_div_zero", 32'(div_zero), 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(32'd100, 32'd7, mk_exp(32'd14, 32'd2, 1'b0));

      // Start while busy at cycle 5 is ignored
      sb.push_back(model(32'h1234_5678, 32'h10));
      launch(32'h1234_5678, 32'h10);
      collect(5);
      @(posedge clk);
      #1;

      // Start held through DONE is ignored there, accepted in the following idle cycle
      sb.push_back(model(32'd1000, 32'd3));
      launch(32'd1000, 32'd3);
      collect(0);
      start    = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      check("done_start_busy", 32'(busy), 32'd0);
      check("done_start_done", 32'(done), 32'd0);
      check("done_start_quot", quotient, 32'd333);
      sb.push_back(model(32'd77, 32'd5));
      launch(32'd77, 32'd5);
      collect(0);
      @(posedge clk);
      #1;

      // Randomised operands against the arithmetic model
      for (int k = 0; k < 6; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_op(ra, rb, model(ra, rb));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
